// File: rtl/execute_muldiv_ctrl_if.sv
// Bundles the execute-stage signals exchanged with the multi-cycle mul/div unit.
// Ports (signals):
//   start_E, op_E[1:0], readData1_E, readData2_E, flush_E  pipeline -> unit
//   stall_E, busy, result_valid, muldivResult_E            unit -> pipeline
// Modports: master = pipeline/execute side, slave = mul/div sequencer.
interface execute_muldiv_ctrl_if #(
    parameter int unsigned WIDTH = 64
);
    logic             start_E;
    logic [1:0]       op_E;
    logic [WIDTH-1:0] readData1_E;
    logic [WIDTH-1:0] readData2_E;
    logic             flush_E;
    logic             stall_E;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] muldivResult_E;

    modport master (
        output start_E, op_E, readData1_E, readData2_E, flush_E,
        input  stall_E, busy, result_valid, muldivResult_E
    );

    modport slave (
        input  start_E, op_E, readData1_E, readData2_E, flush_E,
        output stall_E, busy, result_valid, muldivResult_E
    );
endinterface

// File: rtl/execute_muldiv_ctrl.sv
// Multi-cycle MUL/UDIV/SDIV sequencer beside the LEGv8 execute stage.
// Latches operands on start, iterates one radix-2 step per cycle for WIDTH
// cycles, stalls the pipeline meanwhile and presents the result for one cycle.
// Ports:
//   clk    pipeline clock, rising edge
//   reset  asynchronous active-low reset
//   bus    execute_muldiv_ctrl_if.slave (start/op/operands/flush in;
//          stall/busy/result_valid/result out)
module execute_muldiv_ctrl #(
    parameter int unsigned WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    execute_muldiv_ctrl_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;       // multiplicand (shifts left) / dividend->quotient
    logic [WIDTH-1:0]   r_b;       // multiplier (shifts right) / divisor magnitude
    logic [WIDTH-1:0]   r_acc;     // product accumulator / partial remainder
    logic               r_is_div;
    logic               r_neg;     // SDIV quotient needs negating
    logic [WIDTH-1:0]   r_result;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]   w_a_nxt;
    logic [WIDTH-1:0]   w_b_nxt;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic               w_is_div_nxt;
    logic               w_neg_nxt;
    logic [WIDTH-1:0]   w_result_nxt;

    logic               w_div_op;
    logic               w_sdiv_op;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_mul_acc;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_rem_ge;
    logic [WIDTH-1:0]   w_rem_sub;
    logic [WIDTH-1:0]   w_div_rem;
    logic [WIDTH-1:0]   w_div_quo;
    logic [WIDTH-1:0]   w_quo_fix;
    logic               w_last;

    // Operation decode; 11 falls through to MUL.
    assign w_div_op  = (bus.op_E == 2'b01) || (bus.op_E == 2'b10);
    assign w_sdiv_op = (bus.op_E == 2'b10);

    // SDIV works on magnitudes; MIN_INT keeps its bit pattern, which is its
    // correct unsigned magnitude.
    assign w_a_mag = (w_sdiv_op && bus.readData1_E[WIDTH-1]) ?
                     (~bus.readData1_E + WIDTH'(1)) : bus.readData1_E;
    assign w_b_mag = (w_sdiv_op && bus.readData2_E[WIDTH-1]) ?
                     (~bus.readData2_E + WIDTH'(1)) : bus.readData2_E;

    // One shift-add multiply step.
    assign w_mul_acc = r_b[0] ? (r_acc + r_a) : r_acc;

    // One restoring-division step: bring in the next dividend bit MSB-first.
    assign w_rem_sh  = {r_acc, r_a[WIDTH-1]};
    assign w_rem_ge  = (w_rem_sh >= {1'b0, r_b});
    assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_b;
    assign w_div_rem = w_rem_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0];
    assign w_div_quo = {r_a[WIDTH-2:0], w_rem_ge};
    assign w_quo_fix = r_neg ? (~w_div_quo + WIDTH'(1)) : w_div_quo;

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_acc_nxt    = r_acc;
        w_is_div_nxt = r_is_div;
        w_neg_nxt    = r_neg;
        w_result_nxt = '0;

        case (r_state)
            S_IDLE: begin
                if (bus.start_E && !bus.flush_E) begin
                    w_is_div_nxt = w_div_op;
                    w_neg_nxt    = w_sdiv_op &&
                                   (bus.readData1_E[WIDTH-1] ^ bus.readData2_E[WIDTH-1]);
                    w_cnt_nxt    = '0;
                    w_acc_nxt    = '0;
                    w_a_nxt      = w_a_mag;
                    w_b_nxt      = w_b_mag;
                    // Divide by zero skips iteration and returns 0.
                    if (w_div_op && (bus.readData2_E == '0)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_BUSY;
                    end
                end
            end

            S_BUSY: begin
                if (bus.flush_E) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    if (r_is_div) begin
                        w_acc_nxt = w_div_rem;
                        w_a_nxt   = w_div_quo;
                    end else begin
                        w_acc_nxt = w_mul_acc;
                        w_a_nxt   = {r_a[WIDTH-2:0], 1'b0};
                        w_b_nxt   = {1'b0, r_b[WIDTH-1:1]};
                    end
                    if (w_last) begin
                        w_state_nxt  = S_DONE;
                        w_cnt_nxt    = '0;
                        w_result_nxt = r_is_div ? w_quo_fix : w_mul_acc;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_acc    <= w_acc_nxt;
            r_is_div <= w_is_div_nxt;
            r_neg    <= w_neg_nxt;
            r_result <= w_result_nxt;
        end
    end

    // Stall must hold the pipeline in the accept cycle, so it is combinational;
    // gated by reset so an asserted reset drives it low at once.
    assign bus.stall_E = reset &&
                         (((r_state == S_IDLE) && bus.start_E && !bus.flush_E) ||
                          (r_state == S_BUSY));
    assign bus.busy           = (r_state != S_IDLE);
    assign bus.result_valid   = (r_state == S_DONE) && !bus.flush_E;
    assign bus.muldivResult_E = r_result;
endmodule

// File: tb/tb_execute_muldiv_ctrl.sv
// Directed, table-driven bench for execute_muldiv_ctrl (WIDTH=64).
module tb_execute_muldiv_ctrl;
    localparam int unsigned W = 64;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        logic [7:0]   lat;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    vec_t vecs[14];

    execute_muldiv_ctrl_if #(.WIDTH(W)) bus();

    execute_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_busy"},  W'(bus.busy), W'(0));
        check({name, "_stall"}, W'(bus.stall_E), W'(0));
        check({name, "_rv"},    W'(bus.result_valid), W'(0));
        check({name, "_res"},   bus.muldivResult_E, W'(0));
    endtask

    // Issue an op at a negedge (cycle 0) and return to the caller just after
    // the posedge that ends cycle 0, with start_E dropped.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start_E     = 1'b1;
        bus.op_E        = op;
        bus.readData1_E = a;
        bus.readData2_E = b;
        #1;
        check("stall_cyc0", W'(bus.stall_E), W'(1));
        check("busy_cyc0",  W'(bus.busy), W'(0));
        @(posedge clk);
        #1;
        bus.start_E = 1'b0;
    endtask

    // Run one table vector end to end.
    task automatic run_vec(input vec_t v);
        int lat;
        int stall_cnt;
        lat       = 0;
        stall_cnt = 0;
        issue(v.op, v.a, v.b);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (bus.result_valid) begin
                lat = k;
                break;
            end
            if (bus.stall_E) stall_cnt++;
        end
        check("latency", W'(lat), W'(v.lat));
        check("result", bus.muldivResult_E, v.exp);
        check("stall_done", W'(bus.stall_E), W'(0));
        check("stall_busy_cycles", W'(stall_cnt), W'(v.lat) - W'(1));
        @(negedge clk);
        check_idle("after_done");
    endtask

    task automatic wait_no_valid(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (bus.result_valid) seen++;
        end
        check(name, W'(seen), W'(0));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //          op     a                       b                       expected                lat
        vecs[0]  = '{2'b00, 64'd7,                  64'd6,                  64'd42,                 8'd65};
        vecs[1]  = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                  64'hFFFF_FFFF_FFFF_FFFE, 8'd65};
        vecs[2]  = '{2'b01, 64'd100,                64'd7,                  64'd14,                 8'd65};
        vecs[3]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,                  64'hFFFF_FFFF_FFFF_FFF2, 8'd65};
        vecs[4]  = '{2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 8'd65};
        vecs[5]  = '{2'b01, 64'd1234,               64'd0,                  64'd0,                  8'd1};
        vecs[6]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FF9C, 64'd0,                  64'd0,                  8'd1};
        vecs[7]  = '{2'b11, 64'd3,                  64'd5,                  64'd15,                 8'd65};
        vecs[8]  = '{2'b10, 64'd100,                64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2, 8'd65};
        vecs[9]  = '{2'b10, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14,                 8'd65};
        vecs[10] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10,                 64'h0FFF_FFFF_FFFF_FFFF, 8'd65};
        vecs[11] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,                  64'hFFFF_FFFF_FFFF_FFF1, 8'd65};
        vecs[12] = '{2'b01, 64'd5,                  64'd10,                 64'd0,                  8'd65};
        vecs[13] = '{2'b00, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'd0,                  8'd65};

        reset           = 1'b0;
        bus.start_E     = 1'b0;
        bus.op_E        = 2'b00;
        bus.readData1_E = '0;
        bus.readData2_E = '0;
        bus.flush_E     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i]);
        end

        // start_E raised again mid-operation must not disturb the running MUL.
        begin
            int lat;
            lat = 0;
            issue(2'b00, 64'd7, 64'd6);
            for (int k = 1; k <= 200; k++) begin
                @(negedge clk);
                if (k == 10) begin
                    bus.start_E = 1'b1; bus.op_E = 2'b01;
                    bus.readData1_E = 64'd99; bus.readData2_E = 64'd0;
                end else begin
                    bus.start_E = 1'b0;
                end
                if (bus.result_valid) begin
                    lat = k;
                    break;
                end
            end
            check("restart_latency", W'(lat), W'(65));
            check("restart_result", bus.muldivResult_E, 64'd42);
            @(negedge clk);
            check_idle("restart_after");
        end

        // Flush coincident with start in IDLE: start ignored.
        @(negedge clk);
        bus.start_E = 1'b1; bus.flush_E = 1'b1; bus.op_E = 2'b00;
        bus.readData1_E = 64'd3; bus.readData2_E = 64'd3;
        #1;
        check("flush_start_stall", W'(bus.stall_E), W'(0));
        @(negedge clk);
        bus.start_E = 1'b0; bus.flush_E = 1'b0;
        check_idle("flush_start");

        // Flush of a MUL at cycle 20: IDLE at cycle 21, no result ever.
        issue(2'b00, 64'd7, 64'd6);
        for (int k = 1; k < 20; k++) @(negedge clk);
        bus.flush_E = 1'b1;
        @(negedge clk);
        bus.flush_E = 1'b0;
        #1;
        check_idle("flush_busy");
        wait_no_valid("flush_busy_no_valid", 80);

        // Flush in DONE (divide-by-zero fast path) suppresses result_valid.
        issue(2'b01, 64'd50, 64'd0);
        @(negedge clk);
        check("done_before_flush_rv", W'(bus.result_valid), W'(1));
        bus.flush_E = 1'b1;
        #1;
        check("flush_done_rv", W'(bus.result_valid), W'(0));
        @(negedge clk);
        bus.flush_E = 1'b0;
        check_idle("flush_done_after");

        // Reset pulsed at cycle 30 of a UDIV: outputs clear at once.
        issue(2'b01, 64'd100, 64'd7);
        for (int k = 1; k < 30; k++) @(negedge clk);
        check("pre_reset_busy", W'(bus.busy), W'(1));
        reset = 1'b0;
        #1;
        check_idle("reset_mid");
        @(negedge clk);
        reset = 1'b1;
        wait_no_valid("reset_mid_no_valid", 80);

        // Unit still functional after the abort.
        run_vec(vecs[2]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
